// File: rtl/reg_window_decoder.sv
// ---------------------------------------------------------------------------
// reg_window_decoder
//
// Address decoder and window control for a windowed SPARC register file.
// Holds the current window pointer (CWP) and window invalid mask (WIM),
// executes SAVE/RESTORE with overflow/underflow detection, translates 5-bit
// architectural register numbers into physical array indices and drives a
// registered one-hot write-enable vector into the physical register array.
//
// Physical layout (N = NWINDOWS):
//   0..7                 globals
//   8+16*w .. 15+16*w    outs of window w  (also the ins of window w-1)
//   16+16*w .. 23+16*w   locals of window w
//
// Ports
//   clk        in   1         rising-edge clock
//   reset      in   1         synchronous active-high reset
//   wr_en      in   1         write request this cycle
//   wr_addr    in   5         architectural destination register
//   rd_addr_a  in   5         architectural source A
//   rd_addr_b  in   5         architectural source B
//   rd_phys_a  out  PW        physical index of source A (combinational)
//   rd_phys_b  out  PW        physical index of source B (combinational)
//   we_onehot  out  PHYS      registered one-hot write enable
//   save       in   1         SAVE request
//   restore    in   1         RESTORE request
//   cwp_we     in   1         direct CWP load
//   cwp_din    in   CW        CWP load value
//   wim_we     in   1         WIM load
//   wim_din    in   NWINDOWS  WIM load value
//   cwp        out  CW        current window pointer
//   wim        out  NWINDOWS  current window invalid mask
//   ovf_trap   out  1         one-cycle pulse: SAVE into an invalid window
//   unf_trap   out  1         one-cycle pulse: RESTORE into an invalid window
//   seq_err    out  1         one-cycle pulse: illegal request combination
// ---------------------------------------------------------------------------
module reg_window_decoder #(
   parameter int NWINDOWS = 4,
   // derived, do not override
   parameter int PHYS     = 8 + 16 * NWINDOWS,
   parameter int CW       = $clog2(NWINDOWS),
   parameter int PW       = $clog2(PHYS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [4:0]          wr_addr,
   input  logic [4:0]          rd_addr_a,
   input  logic [4:0]          rd_addr_b,
   output logic [PW-1:0]       rd_phys_a,
   output logic [PW-1:0]       rd_phys_b,
   output logic [PHYS-1:0]     we_onehot,
   input  logic                save,
   input  logic                restore,
   input  logic                cwp_we,
   input  logic [CW-1:0]       cwp_din,
   input  logic                wim_we,
   input  logic [NWINDOWS-1:0] wim_din,
   output logic [CW-1:0]       cwp,
   output logic [NWINDOWS-1:0] wim,
   output logic                ovf_trap,
   output logic                unf_trap,
   output logic                seq_err
);

   // Window neighbours with explicit wrap so non-power-of-two window
   // counts stay inside 0..N-1.
   function automatic logic [CW-1:0] win_inc(input logic [CW-1:0] w);
      win_inc = (w == CW'(NWINDOWS - 1)) ? '0 : w + 1'b1;
   endfunction

   function automatic logic [CW-1:0] win_dec(input logic [CW-1:0] w);
      win_dec = (w == '0) ? CW'(NWINDOWS - 1) : w - 1'b1;
   endfunction

   // Outs and locals of window w both sit at r + 16*w; the ins are the outs
   // of the next window, i.e. (r - 16) + 16*((w+1) mod N).
   function automatic logic [PW-1:0] phys_of(input logic [4:0] r,
                                             input logic [CW-1:0] w);
      logic [CW-1:0] wn;
      wn = win_inc(w);
      if (r < 5'd8)
         phys_of = PW'(r);
      else if (r < 5'd24)
         phys_of = PW'(r) + PW'({w, 4'b0000});
      else
         phys_of = PW'(r) - PW'(16) + PW'({wn, 4'b0000});
   endfunction

   logic [CW-1:0]       r_cwp;
   logic [NWINDOWS-1:0] r_wim;
   logic [PHYS-1:0]     r_we_onehot;
   logic                r_ovf_trap;
   logic                r_unf_trap;
   logic                r_seq_err;

   logic [CW-1:0]       w_cwp_dec;
   logic [CW-1:0]       w_cwp_inc;
   logic [PW-1:0]       w_wr_phys;
   logic [PHYS-1:0]     w_wr_onehot;
   logic                w_din_ok;

   assign w_cwp_dec   = win_dec(r_cwp);
   assign w_cwp_inc   = win_inc(r_cwp);
   assign w_wr_phys   = phys_of(wr_addr, r_cwp);
   assign w_wr_onehot = {{(PHYS-1){1'b0}}, 1'b1} << w_wr_phys;
   assign w_din_ok    = (int'(cwp_din) < NWINDOWS);

   assign rd_phys_a = phys_of(rd_addr_a, r_cwp);
   assign rd_phys_b = phys_of(rd_addr_b, r_cwp);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cwp       <= '0;
         r_wim       <= '0;
         r_we_onehot <= '0;
         r_ovf_trap  <= 1'b0;
         r_unf_trap  <= 1'b0;
         r_seq_err   <= 1'b0;
      end else begin
         // Write enable uses the CWP before any update in this cycle;
         // g0 is never written.
         r_we_onehot <= (wr_en && (wr_addr != 5'd0)) ? w_wr_onehot : '0;

         r_ovf_trap <= 1'b0;
         r_unf_trap <= 1'b0;
         r_seq_err  <= 1'b0;

         // Direct load beats SAVE/RESTORE; simultaneous SAVE and RESTORE
         // is rejected. Trap checks read the WIM before any same-cycle load.
         if (cwp_we) begin
            if (w_din_ok)
               r_cwp <= cwp_din;
            else
               r_seq_err <= 1'b1;
         end else if (save && restore) begin
            r_seq_err <= 1'b1;
         end else if (save) begin
            if (r_wim[w_cwp_dec])
               r_ovf_trap <= 1'b1;
            else
               r_cwp <= w_cwp_dec;
         end else if (restore) begin
            if (r_wim[w_cwp_inc])
               r_unf_trap <= 1'b1;
            else
               r_cwp <= w_cwp_inc;
         end

         if (wim_we)
            r_wim <= wim_din;
      end
   end

   assign cwp       = r_cwp;
   assign wim       = r_wim;
   assign we_onehot = r_we_onehot;
   assign ovf_trap  = r_ovf_trap;
   assign unf_trap  = r_unf_trap;
   assign seq_err   = r_seq_err;

endmodule
